// File: rtl/dcache_store_port_responder_pkg.sv
// rtl/dcache_store_port_responder_pkg.sv - shared types and constants for the D$ port responder
package dcache_store_port_responder_pkg;

    localparam int unsigned XLEN               = 64;
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;
    localparam int unsigned RESP_DEPTH_DEFAULT = 256;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [XLEN-1:0]               data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [(XLEN/8)-1:0]           data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic            data_gnt;
        logic            data_rvalid;
        logic [XLEN-1:0] data_rdata;
    } dcache_req_o_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GNT  = 2'd1,
        READ_TAG  = 2'd2,
        READ_RESP = 2'd3
    } resp_state_e;

endpackage

// File: rtl/dcache_store_port_responder_if.sv
// rtl/dcache_store_port_responder_if.sv - D$ request/response port bundle
interface dcache_store_port_responder_if;
    import dcache_store_port_responder_pkg::*;

    dcache_req_i_t req_port_i;
    dcache_req_o_t req_port_o;

    modport master (output req_port_i, input req_port_o);
    modport slave  (input req_port_i, output req_port_o);

endinterface

// File: rtl/dcache_resp_mem.sv
// rtl/dcache_resp_mem.sv - byte-enable write, async read word memory with async clear
module dcache_resp_mem
    import dcache_store_port_responder_pkg::*;
#(
    parameter int unsigned DEPTH = RESP_DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [XLEN-1:0]          wdata_i,
    input  logic [(XLEN/8)-1:0]      be_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [XLEN-1:0]          rdata_o,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr_i,
    output logic [XLEN-1:0]          dbg_rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    // Clear everything on reset; otherwise merge enabled bytes into the addressed word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < int'(XLEN/8); b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Both read ports see the pre-edge contents of the array.
    assign rdata_o     = mem_q[raddr_i];
    assign dbg_rdata_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/dcache_store_port_responder.sv
// rtl/dcache_store_port_responder.sv - D$ request-port responder with programmable grant delay
module dcache_store_port_responder
    import dcache_store_port_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = RESP_DEPTH_DEFAULT,
    parameter int unsigned MAX_DELAY_W = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    dcache_store_port_responder_if.slave req_port,
    input  logic [MAX_DELAY_W-1:0]       gnt_delay_i,
    input  logic                         stall_i,
    input  logic [$clog2(DEPTH)-1:0]     dbg_addr_i,
    output logic [XLEN-1:0]              dbg_rdata_o,
    output logic [31:0]                  wr_count_o,
    output logic                         err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BO = $clog2(XLEN/8);
    localparam int unsigned PW = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;

    dcache_req_i_t                 req;
    resp_state_e                   state_q, state_d;
    logic [MAX_DELAY_W-1:0]        cnt_q, cnt_d;
    logic [DCACHE_INDEX_WIDTH-1:0] rd_index_q;
    logic [XLEN-1:0]               rdata_q;
    logic [XLEN-1:0]               mem_rdata;
    logic [PW-1:0]                 wr_paddr;
    logic [PW-1:0]                 rd_paddr;
    logic                          accepting;
    logic                          gnt;
    logic                          kill_err;
    logic                          tag_err;
    logic                          mem_we;
    logic                          unused_bits;

    assign req       = req_port.req_port_i;
    // Reads use the index captured at grant with the tag that arrives one cycle later.
    assign wr_paddr  = {req.address_tag, req.address_index};
    assign rd_paddr  = {req.address_tag, rd_index_q};
    // READ_RESP behaves like IDLE for new requests so reads can be pipelined.
    assign accepting = (state_q == IDLE) || (state_q == READ_RESP);
    assign kill_err  = req.data_req && req.kill_req && (accepting || state_q == WAIT_GNT);
    assign tag_err   = ((state_q == READ_TAG) && !req.tag_valid && !req.kill_req) ||
                       (gnt && req.data_we && !req.tag_valid);
    assign mem_we    = gnt && req.data_we;
    // Upper address bits alias and data_size is ignored; data_be decides the write.
    assign unused_bits = ^{req.data_size, wr_paddr, rd_paddr};

    // State and grant-delay counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: count unstalled request cycles until the grant, then branch on write/read.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, READ_RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (gnt) begin
                    state_d = req.data_we ? IDLE : READ_TAG;
                end else if (req.data_req) begin
                    state_d = WAIT_GNT;
                    cnt_d   = stall_i ? '0 : MAX_DELAY_W'(1);
                end
            end
            WAIT_GNT: begin
                if (!req.data_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (gnt) begin
                    state_d = req.data_we ? IDLE : READ_TAG;
                    cnt_d   = '0;
                end else if (!stall_i && (cnt_q != '1)) begin
                    cnt_d = cnt_q + MAX_DELAY_W'(1);
                end
            end
            READ_TAG: begin
                state_d = req.tag_valid ? READ_RESP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grant is combinational on the request; reset forces it low at once.
    always_comb begin
        gnt = 1'b0;
        if (req.data_req && !req.kill_req && !stall_i && !rst_i) begin
            if (accepting) begin
                gnt = (gnt_delay_i == '0);
            end else if (state_q == WAIT_GNT) begin
                gnt = (cnt_q >= gnt_delay_i);
            end
        end
        req_port.req_port_o.data_gnt    = gnt;
        req_port.req_port_o.data_rvalid = (state_q == READ_RESP);
        req_port.req_port_o.data_rdata  = rdata_q;
    end

    // Read index/data capture, saturating write counter and sticky protocol error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_index_q <= '0;
            rdata_q    <= '0;
            wr_count_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (gnt && !req.data_we) begin
                rd_index_q <= req.address_index;
            end
            if ((state_q == READ_TAG) && req.tag_valid) begin
                rdata_q <= mem_rdata;
            end
            if (mem_we && (wr_count_o != '1)) begin
                wr_count_o <= wr_count_o + 32'd1;
            end
            if (kill_err || tag_err) begin
                err_o <= 1'b1;
            end
        end
    end

    dcache_resp_mem #(
        .DEPTH(DEPTH)
    ) i_mem (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we_i       (mem_we),
        .waddr_i    (wr_paddr[BO +: AW]),
        .wdata_i    (req.data_wdata),
        .be_i       (req.data_be),
        .raddr_i    (rd_paddr[BO +: AW]),
        .rdata_o    (mem_rdata),
        .dbg_addr_i (dbg_addr_i),
        .dbg_rdata_o(dbg_rdata_o)
    );

endmodule

// File: tb/tb_dcache_store_port_responder.sv
// tb/tb_dcache_store_port_responder.sv - scoreboard bench for the D$ port responder
module tb_dcache_store_port_responder;
    import dcache_store_port_responder_pkg::*;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  gnt_delay;
    logic        stall;
    logic [7:0]  dbg_addr;
    logic [63:0] dbg_rdata;
    logic [31:0] wr_count;
    logic        err;

    int      cyc = 0;
    int      tests = 0;
    int      fails = 0;
    int      gnt_q[$];
    rd_exp_t rd_q[$];
    int      e_cyc;
    rd_exp_t e_rd;
    logic [63:0] dbg_seen;

    dcache_store_port_responder_if bus();

    dcache_store_port_responder #(.DEPTH(256), .MAX_DELAY_W(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_port   (bus.slave),
        .gnt_delay_i(gnt_delay),
        .stall_i    (stall),
        .dbg_addr_i (dbg_addr),
        .dbg_rdata_o(dbg_rdata),
        .wr_count_o (wr_count),
        .err_o      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    // Monitor: every grant and every rvalid must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_port_o.data_gnt) begin
                if (gnt_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_gnt: got grant at cycle %0d required none", cyc);
                end else begin
                    e_cyc = gnt_q.pop_front();
                    chk("gnt_cycle", 64'(cyc), 64'(e_cyc));
                end
            end
            if (bus.req_port_o.data_rvalid) begin
                if (rd_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rvalid: got rvalid at cycle %0d required none", cyc);
                end else begin
                    e_rd = rd_q.pop_front();
                    chk("rvalid_cycle", 64'(cyc), 64'(e_rd.cyc));
                    chk("rdata", bus.req_port_o.data_rdata, e_rd.data);
                end
            end
        end
    end

    task automatic set_addr(input logic [55:0] paddr);
        bus.req_port_i.address_index = paddr[11:0];
        bus.req_port_i.address_tag   = paddr[55:12];
    endtask

    // Drive one request and hold it until granted; the expected grant cycle is queued first.
    task automatic issue(input logic we, input logic [55:0] paddr, input logic [63:0] wd,
                         input logic [7:0] be, input logic [3:0] dly, input int lat,
                         input int stall_n, output logic [63:0] dbg_at_gnt);
        bit got;
        got = 1'b0;
        dbg_at_gnt = '0;
        set_addr(paddr);
        bus.req_port_i.data_wdata = wd;
        bus.req_port_i.data_be    = be;
        bus.req_port_i.data_we    = we;
        bus.req_port_i.tag_valid  = we;
        bus.req_port_i.data_req   = 1'b1;
        gnt_delay = dly;
        stall     = (stall_n > 0);
        gnt_q.push_back(cyc + lat);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.req_port_o.data_gnt) begin
                got = 1'b1;
                dbg_at_gnt = dbg_rdata;
            end
            @(posedge clk); #1;
            if (i + 1 == stall_n) stall = 1'b0;
        end
        bus.req_port_i.data_req  = 1'b0;
        bus.req_port_i.data_we   = 1'b0;
        bus.req_port_i.tag_valid = 1'b0;
        stall = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL gnt_timeout: got no grant in 40 cycles required grant at latency %0d", lat);
            if (gnt_q.size() > 0) void'(gnt_q.pop_front());
        end
    endtask

    // Read: grant, then present the tag (or kill) in the following cycle.
    task automatic do_read(input logic [55:0] paddr, input bit kill, input logic [63:0] exp);
        logic [63:0] d;
        rd_exp_t r;
        issue(1'b0, paddr, 64'h0, 8'h00, 4'd0, 0, 0, d);
        set_addr(paddr);
        if (kill) begin
            bus.req_port_i.kill_req = 1'b1;
        end else begin
            bus.req_port_i.tag_valid = 1'b1;
            r.cyc  = cyc + 1;
            r.data = exp;
            rd_q.push_back(r);
        end
        @(posedge clk); #1;
        bus.req_port_i.kill_req  = 1'b0;
        bus.req_port_i.tag_valid = 1'b0;
    endtask

    initial begin
        bus.req_port_i = '0;
        rst = 1'b1;
        gnt_delay = 4'd0;
        stall = 1'b0;
        dbg_addr = 8'd2;

        @(posedge clk); #1;
        chk("rst_gnt", 64'(bus.req_port_o.data_gnt), 64'd0);
        chk("rst_rvalid", 64'(bus.req_port_o.data_rvalid), 64'd0);
        chk("rst_rdata", bus.req_port_o.data_rdata, 64'd0);
        chk("rst_wr_count", 64'(wr_count), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_mem", dbg_rdata, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero delay full-word write
        issue(1'b1, 56'h10, 64'h1122334455667788, 8'hFF, 4'd0, 0, 0, dbg_seen);
        chk("w0_word", dbg_rdata, 64'h1122334455667788);
        chk("w0_count", 64'(wr_count), 64'd1);

        // Delay 3, low-half byte enables
        issue(1'b1, 56'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F, 4'd3, 3, 0, dbg_seen);
        chk("w1_word", dbg_rdata, 64'h11223344BBBBBBBB);
        chk("w1_count", 64'(wr_count), 64'd2);

        // Tagged read of word 2
        do_read(56'h10, 1'b0, 64'h11223344BBBBBBBB);
        @(posedge clk); #1;
        chk("read_err", 64'(err), 64'd0);

        // Read killed in the tag cycle, then a normal write
        do_read(56'h10, 1'b1, 64'h0);
        @(posedge clk); #1;
        chk("kill_err", 64'(err), 64'd0);
        issue(1'b1, 56'h18, 64'h0123456789ABCDEF, 8'hFF, 4'd0, 0, 0, dbg_seen);
        dbg_addr = 8'd3;
        #1;
        chk("after_kill_word", dbg_rdata, 64'h0123456789ABCDEF);

        // Stall five cycles with delay 1: grant on the 2nd unstalled cycle
        issue(1'b1, 56'h20, 64'hCAFEBABEDEADBEEF, 8'hF0, 4'd1, 6, 5, dbg_seen);
        dbg_addr = 8'd4;
        #1;
        chk("stall_word", dbg_rdata, 64'hCAFEBABE00000000);
        chk("stall_count", 64'(wr_count), 64'd4);

        // Write then read the same word in consecutive cycles; debug port shows old data at the edge
        dbg_addr = 8'd5;
        issue(1'b1, 56'h28, 64'h5555AAAA5555AAAA, 8'hFF, 4'd0, 0, 0, dbg_seen);
        chk("dbg_old_at_gnt", dbg_seen, 64'h0);
        do_read(56'h28, 1'b0, 64'h5555AAAA5555AAAA);
        @(posedge clk); #1;

        // kill_req while waiting for the grant sets the sticky error
        set_addr(56'h30);
        bus.req_port_i.data_we   = 1'b1;
        bus.req_port_i.tag_valid = 1'b1;
        bus.req_port_i.data_req  = 1'b1;
        gnt_delay = 4'd2;
        @(posedge clk); #1;
        bus.req_port_i.kill_req = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.req_port_i.kill_req = 1'b0;
        bus.req_port_i.data_req = 1'b0;
        @(posedge clk); #1;
        chk("kill_wait_err", 64'(err), 64'd1);

        // Reset in the middle of WAIT_GNT
        dbg_addr = 8'd2;
        set_addr(56'h10);
        bus.req_port_i.data_wdata = 64'hFFFFFFFFFFFFFFFF;
        bus.req_port_i.data_be    = 8'hFF;
        bus.req_port_i.data_we    = 1'b1;
        bus.req_port_i.tag_valid  = 1'b1;
        bus.req_port_i.data_req   = 1'b1;
        gnt_delay = 4'd4;
        repeat (2) begin @(posedge clk); #1; end
        #1;
        rst = 1'b1;
        gnt_delay = 4'd0;
        #1;
        chk("mid_rst_gnt", 64'(bus.req_port_o.data_gnt), 64'd0);
        chk("mid_rst_mem", dbg_rdata, 64'd0);
        chk("mid_rst_count", 64'(wr_count), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        bus.req_port_i = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Normal operation after reset
        issue(1'b1, 56'h10, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 4'd0, 0, 0, dbg_seen);
        chk("post_rst_word", dbg_rdata, 64'h0F0F0F0F0F0F0F0F);
        chk("post_rst_count", 64'(wr_count), 64'd1);

        repeat (4) @(posedge clk);
        #1;
        chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion required finish before 100000");
        $fatal(1);
    end

endmodule
